// File: rtl/addsub_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter_pkg
// Brief    : Shared state encoding and saturation constants for addsub_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/addsub_arbiter_cla_16b.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter_cla_16b
// Brief    : CLA_16b - 16-bit saturating add/sub, 4x4-bit carry-lookahead.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter_cla_16b
    import addsub_arbiter_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] s,
    output logic        ovfl,
    output logic        neg
);

    logic [15:0] w_b_eff;
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;
    logic [15:0] w_raw;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [3:0]  w_gc;

    always_comb begin
        w_b_eff = sub ? ~b : b;
        w_p     = a ^ w_b_eff;
        w_g     = a & w_b_eff;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (&w_p[4*k+2 +: 2] & w_g[4*k+1])
                    | (&w_p[4*k+1 +: 3] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
        // Subtraction is A + ~B + 1, so the carry-in doubles as the op select
        w_gc[0] = sub;
        for (int k = 0; k < 3; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            w_c[4*k] = w_gc[k];
            for (int j = 0; j < 3; j++) begin
                w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
            end
        end
        w_raw = w_p ^ w_c;

        s    = w_raw;
        ovfl = 1'b0;
        if (a[15] && w_b_eff[15] && !w_raw[15]) begin
            s    = SAT_NEG;
            ovfl = 1'b1;
        end else if (!a[15] && !w_b_eff[15] && w_raw[15]) begin
            s    = SAT_POS;
            ovfl = 1'b1;
        end
        neg = s[15];
    end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter
// Brief    : Round-robin sharing of one saturating add/sub unit, 2-cycle ops.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [WIDTH*NUM_REQ-1:0]   op_a,
    input  logic [WIDTH*NUM_REQ-1:0]   op_b,
    input  logic [NUM_REQ-1:0]         sub,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           result,
    output logic                       ovfl,
    output logic                       neg
);

    localparam int IDXW = (NUM_REQ > 2) ? 2 : 1;

    state_t            r_state;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sub;

    logic [IDXW:0]     w_pick;
    logic              w_any;
    logic [IDXW-1:0]   w_win;
    logic [IDXW-1:0]   w_next_ptr;
    logic [WIDTH-1:0]  w_s;
    logic              w_ovfl;
    logic              w_neg;

    // Scans downward so the requester closest to ptr (upward, wrapping) wins last
    function automatic logic [IDXW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDXW-1:0]    ptr);
        logic [IDXW:0] pick;
        int            idx;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (r[idx]) pick = {1'b1, IDXW'(idx)};
        end
        return pick;
    endfunction

    always_comb begin
        w_pick     = rr_pick(req, r_rr_ptr);
        w_any      = w_pick[IDXW];
        w_win      = w_pick[IDXW-1:0];
        w_next_ptr = (w_win == IDXW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        gnt        = '0;
        if (r_state == ST_IDLE && w_any) gnt[w_win] = 1'b1;
        busy       = (r_state == ST_EXEC);
    end

    addsub_arbiter_cla_16b u_cla (
        .a    (r_a),
        .b    (r_b),
        .sub  (r_sub),
        .s    (w_s),
        .ovfl (w_ovfl),
        .neg  (w_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            resp_valid <= '0;
            result     <= '0;
            ovfl       <= 1'b0;
            neg        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    resp_valid <= '0;
                    if (w_any) begin
                        r_a      <= op_a[int'(w_win)*WIDTH +: WIDTH];
                        r_b      <= op_b[int'(w_win)*WIDTH +: WIDTH];
                        r_sub    <= sub[w_win];
                        r_idx    <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result     <= w_s;
                    ovfl       <= w_ovfl;
                    neg        <= w_neg;
                    resp_valid <= NUM_REQ'(1) << r_idx;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_arbiter
// Brief    : Directed self-checking bench for addsub_arbiter (NUM_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  sub;
    logic [1:0]  gnt;
    logic        busy;
    logic [1:0]  resp_valid;
    logic [15:0] result;
    logic        ovfl;
    logic        neg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.NUM_REQ(2), .WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub        (sub),
        .gnt        (gnt),
        .busy       (busy),
        .resp_valid (resp_valid),
        .result     (result),
        .ovfl       (ovfl),
        .neg        (neg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; op_a = '0; op_b = '0; sub = 2'b00;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b expected 00", resp_valid); end
        checks++; if ({result, ovfl, neg} !== 18'h0) begin errors++; $display("FAIL reset_result: got %h/%b/%b expected 0000/0/0", result, ovfl, neg); end
        tick();
    endtask

    task automatic test_basic();
        op_a[15:0] = 16'h0005; op_b[15:0] = 16'h0003; sub[0] = 1'b1; req = 2'b01;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b expected 01", gnt); end
        tick(); req = 2'b00;
        #1;
        checks++; if (busy !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL basic_busy: got busy=%b gnt=%b expected 1/00", busy, gnt); end
        tick();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL basic_resp: got %b expected 01", resp_valid); end
        checks++; if ({result, ovfl, neg} !== {16'h0002, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_result: got %h/%b/%b expected 0002/0/0", result, ovfl, neg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b expected 0", busy); end
        tick();
        checks++; if (resp_valid !== 2'b00 || result !== 16'h0002) begin errors++; $display("FAIL basic_hold: got resp=%b result=%h expected 00/0002", resp_valid, result); end
    endtask

    task automatic test_saturation();
        // rr_ptr is 1 after serving requester 0
        op_a[31:16] = 16'h7FFF; op_b[31:16] = 16'h0001; sub[1] = 1'b0; req = 2'b10;
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL satpos_gnt: got %b expected 10", gnt); end
        tick(); req = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b10 || {result, ovfl, neg} !== {16'h7FFF, 1'b1, 1'b0}) begin errors++; $display("FAIL satpos_result: got resp=%b %h/%b/%b expected 10 7fff/1/0", resp_valid, result, ovfl, neg); end
        op_a[15:0] = 16'h8000; op_b[15:0] = 16'hFFFF; sub[0] = 1'b0; req = 2'b01;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL satneg_gnt_b2b: got %b expected 01", gnt); end
        tick(); req = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b01 || {result, ovfl, neg} !== {16'h8000, 1'b1, 1'b1}) begin errors++; $display("FAIL satneg_result: got resp=%b %h/%b/%b expected 01 8000/1/1", resp_valid, result, ovfl, neg); end
        op_a[31:16] = 16'h0003; op_b[31:16] = 16'h0005; sub[1] = 1'b1; req = 2'b10;
        tick(); req = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b10 || {result, ovfl, neg} !== {16'hFFFE, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_negative: got resp=%b %h/%b/%b expected 10 fffe/0/1", resp_valid, result, ovfl, neg); end
        op_a[15:0] = 16'h8000; op_b[15:0] = 16'h0001; sub[0] = 1'b1; req = 2'b01;
        tick(); req = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b01 || {result, ovfl, neg} !== {16'h8000, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_satneg: got resp=%b %h/%b/%b expected 01 8000/1/1", resp_valid, result, ovfl, neg); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt;
        logic [1:0]  prev_gnt;
        logic [15:0] prev_res;
        rst = 1'b1;
        op_a = {16'h0100, 16'h0010}; op_b = {16'h0001, 16'h0001}; sub = 2'b10; req = 2'b11;
        tick(); tick();
        rst = 1'b0;
        prev_gnt = 2'b00; prev_res = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
            checks++; if (resp_valid !== prev_gnt || result !== prev_res) begin errors++; $display("FAIL rr_resp[%0d]: got %b/%h expected %b/%h", k, resp_valid, result, prev_gnt, prev_res); end
            tick();
            checks++; if (busy !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL rr_busy[%0d]: got busy=%b gnt=%b expected 1/00", k, busy, gnt); end
            tick();
            prev_gnt = exp_gnt;
            prev_res = (k % 2 == 0) ? 16'h0011 : 16'h00FF;
        end
        req = 2'b00;
        #1;
        checks++; if (resp_valid !== 2'b10 || result !== 16'h00FF) begin errors++; $display("FAIL rr_last: got %b/%h expected 10/00ff", resp_valid, result); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] prev_res;
        prev_res = 16'h0000;
        sub[1] = 1'b0; op_b[31:16] = 16'h0004; req = 2'b10;
        for (int k = 0; k < 3; k++) begin
            op_a[31:16] = 16'(k + 3);
            #1;
            checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 10", k, gnt); end
            if (k > 0) begin
                checks++; if (resp_valid !== 2'b10 || result !== prev_res) begin errors++; $display("FAIL b2b_resp[%0d]: got %b/%h expected 10/%h", k, resp_valid, result, prev_res); end
            end
            tick();
            tick();
            prev_res = 16'(k + 7);
        end
        req = 2'b00;
        #1;
        checks++; if (resp_valid !== 2'b10 || result !== 16'h0009) begin errors++; $display("FAIL b2b_last: got %b/%h expected 10/0009", resp_valid, result); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        op_a[15:0] = 16'h1234; op_b[15:0] = 16'h0001; sub[0] = 1'b0; req = 2'b01;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstexec_gnt: got %b expected 01", gnt); end
        tick();
        rst = 1'b1; req = 2'b00;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstexec_drop: got resp=%b busy=%b expected 00/0", resp_valid, busy); end
        checks++; if ({result, ovfl, neg} !== 18'h0) begin errors++; $display("FAIL rstexec_result: got %h/%b/%b expected 0000/0/0", result, ovfl, neg); end
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rstexec_noresp: got %b expected 00", resp_valid); end
        // Both requesting: only a cleared pointer picks requester 0
        op_a[15:0] = 16'h0020; op_b[15:0] = 16'h0002; sub[0] = 1'b1; req = 2'b11;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstexec_ptr: got %b expected 01", gnt); end
        tick(); req = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b01 || {result, ovfl, neg} !== {16'h001E, 1'b0, 1'b0}) begin errors++; $display("FAIL rstexec_next: got %b %h/%b/%b expected 01 001e/0/0", resp_valid, result, ovfl, neg); end
        tick();
    endtask

    task automatic test_operand_change();
        op_a[15:0] = 16'h1234; op_b[15:0] = 16'h0001; sub[0] = 1'b0; req = 2'b01;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL opchg_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b11; op_a[15:0] = 16'hFFFF; op_b[15:0] = 16'hFFFF; sub[0] = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL opchg_nognt: got %b expected 00", gnt); end
        tick(); req = 2'b00;
        #1;
        checks++; if (resp_valid !== 2'b01 || {result, ovfl, neg} !== {16'h1235, 1'b0, 1'b0}) begin errors++; $display("FAIL opchg_result: got %b %h/%b/%b expected 01 1235/0/0", resp_valid, result, ovfl, neg); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_exec();
        test_operand_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
